// File: rtl/stats_engine.sv
// Per-port packet statistics with a freezable snapshot and a registered 32-bit indexed read window.
// Counters are fed from a one-stage registered copy of the attribute vector.
module stats_engine #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int TIMESTAMP_WIDTH      = 64,
  parameter int ATTRIBUTE_DATA_WIDTH = 135,
  parameter int NUM_INPUT_QUEUES     = 8,
  parameter int TUPLE_WIDTH          = 104,
  parameter int BYTES_COUNT_WIDTH    = 16,
  parameter int NUM_PORTS            = 4,
  parameter int CNT_WIDTH            = 48,
  parameter int SATURATE             = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ATTRIBUTE_DATA_WIDTH-1:0] pkt_attributes,
  input  logic                            pkt_valid,
  input  logic [TIMESTAMP_WIDTH-1:0]      stamp_counter,
  input  logic                            stats_freeze,
  input  logic                            rst_stats,
  input  logic [NUM_PORTS-1:0]            clr_port_mask,
  input  logic                            rd_req,
  input  logic [7:0]                      rd_port,
  input  logic [2:0]                      rd_sel,
  input  logic                            rd_hi,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                            rd_valid,
  output logic                            rd_err
);

  localparam int NCNT     = 6;
  localparam int FLAG_LSB = TUPLE_WIDTH + BYTES_COUNT_WIDTH;
  localparam int SRC_LSB  = ATTRIBUTE_DATA_WIDTH - NUM_INPUT_QUEUES;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (SATURATE != 0 && s[CNT_WIDTH]) return '1;
    return s[CNT_WIDTH-1:0];
  endfunction

  logic                         vld_p1;
  logic [NUM_INPUT_QUEUES-1:0]  src_p1;
  logic [BYTES_COUNT_WIDTH-1:0] bytes_p1;
  logic [4:0]                   flags_p1;

  logic unused_attr;
  assign unused_attr = ^{pkt_attributes[TUPLE_WIDTH-1:0], pkt_attributes[SRC_LSB-1:FLAG_LSB+5]};

  // Stage 1: register the fields the counters consume
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= pkt_valid;
  end

  always_ff @(posedge clk) begin
    src_p1   <= pkt_attributes[SRC_LSB +: NUM_INPUT_QUEUES];
    bytes_p1 <= pkt_attributes[TUPLE_WIDTH +: BYTES_COUNT_WIDTH];
    flags_p1 <= pkt_attributes[FLAG_LSB +: 5];
  end

  logic [CNT_WIDTH-1:0] live     [NUM_PORTS][NCNT];
  logic [CNT_WIDTH-1:0] live_nxt [NUM_PORTS][NCNT];
  logic [CNT_WIDTH-1:0] unm, unm_nxt;
  logic [CNT_WIDTH-1:0] inc [NCNT];
  logic [NUM_PORTS-1:0] hit;

  // Stage 2: live counters; flags are IP, TCP, UDP, VLAN_Q, VLAN_AD from LSB up
  always_comb begin
    inc[0] = CNT_WIDTH'(1);
    inc[1] = CNT_WIDTH'(bytes_p1);
    inc[2] = CNT_WIDTH'(flags_p1[3] | flags_p1[4]);
    inc[3] = CNT_WIDTH'(flags_p1[0]);
    inc[4] = CNT_WIDTH'(flags_p1[1]);
    inc[5] = CNT_WIDTH'(flags_p1[2]);
    for (int p = 0; p < NUM_PORTS; p++)
      hit[p] = vld_p1 && (src_p1 == (NUM_INPUT_QUEUES'(1) << (2 * p)));
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int k = 0; k < NCNT; k++) begin
        if (rst_stats || clr_port_mask[p]) live_nxt[p][k] = '0;
        else if (hit[p])                   live_nxt[p][k] = sat_add(live[p][k], inc[k]);
        else                               live_nxt[p][k] = live[p][k];
      end
    end
    if (rst_stats)                 unm_nxt = '0;
    else if (vld_p1 && hit == '0)  unm_nxt = sat_add(unm, CNT_WIDTH'(1));
    else                           unm_nxt = unm;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++)
        for (int k = 0; k < NCNT; k++) live[p][k] <= '0;
      unm <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        for (int k = 0; k < NCNT; k++) live[p][k] <= live_nxt[p][k];
      unm <= unm_nxt;
    end
  end

  logic [CNT_WIDTH-1:0]       snap [NUM_PORTS][NCNT];
  logic [CNT_WIDTH-1:0]       snap_unm;
  logic [TIMESTAMP_WIDTH-1:0] snap_ts;

  // Stage 3: snapshot follows live state unless frozen
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++)
        for (int k = 0; k < NCNT; k++) snap[p][k] <= '0;
      snap_unm <= '0;
      snap_ts  <= '0;
    end else if (!stats_freeze) begin
      for (int p = 0; p < NUM_PORTS; p++)
        for (int k = 0; k < NCNT; k++) snap[p][k] <= live[p][k];
      snap_unm <= unm;
      snap_ts  <= stamp_counter;
    end
  end

  logic [63:0] rd_val;
  logic        rd_bad;

  always_comb begin
    rd_val = '0;
    rd_bad = 1'b0;
    case (rd_sel)
      3'd6: rd_val = 64'(snap_ts);
      3'd7: rd_val = 64'(snap_unm);
      default: begin
        rd_bad = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (rd_port == 8'(p)) begin
            rd_bad = 1'b0;
            rd_val = 64'(snap[p][rd_sel]);
          end
        end
      end
    endcase
  end

  // Read response register; data holds between strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_err   <= rd_req & rd_bad;
      if (rd_req) rd_data <= rd_hi ? rd_val[63:32] : rd_val[31:0];
    end
  end

endmodule

// File: tb/tb_stats_engine.sv
// Scoreboarded random bench for stats_engine: three configurations (32-bit saturating,
// 32-bit wrapping, 48-bit wrapping) share one stimulus stream and one ideal-count model.
module tb_stats_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [134:0] pkt_attributes;
  logic         pkt_valid;
  logic [63:0]  stamp_counter;
  logic         stats_freeze;
  logic         rst_stats;
  logic [3:0]   clr_port_mask;
  logic         rd_req;
  logic [7:0]   rd_port;
  logic [2:0]   rd_sel;
  logic         rd_hi;
  logic [2:0][31:0] rd_data;
  logic [2:0]       rd_valid;
  logic [2:0]       rd_err;

  stats_engine #(.CNT_WIDTH(32), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .pkt_attributes(pkt_attributes), .pkt_valid(pkt_valid),
    .stamp_counter(stamp_counter), .stats_freeze(stats_freeze), .rst_stats(rst_stats),
    .clr_port_mask(clr_port_mask), .rd_req(rd_req), .rd_port(rd_port), .rd_sel(rd_sel),
    .rd_hi(rd_hi), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .rd_err(rd_err[0]));

  stats_engine #(.CNT_WIDTH(32), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .pkt_attributes(pkt_attributes), .pkt_valid(pkt_valid),
    .stamp_counter(stamp_counter), .stats_freeze(stats_freeze), .rst_stats(rst_stats),
    .clr_port_mask(clr_port_mask), .rd_req(rd_req), .rd_port(rd_port), .rd_sel(rd_sel),
    .rd_hi(rd_hi), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .rd_err(rd_err[1]));

  stats_engine #(.CNT_WIDTH(48), .SATURATE(0)) u_wide (
    .clk(clk), .reset(reset), .pkt_attributes(pkt_attributes), .pkt_valid(pkt_valid),
    .stamp_counter(stamp_counter), .stats_freeze(stats_freeze), .rst_stats(rst_stats),
    .clr_port_mask(clr_port_mask), .rd_req(rd_req), .rd_port(rd_port), .rd_sel(rd_sel),
    .rd_hi(rd_hi), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .rd_err(rd_err[2]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int cfg_w(input int i);
    return (i == 2) ? 48 : 32;
  endfunction

  function automatic bit cfg_sat(input int i);
    return i == 0;
  endfunction

  // Ideal (unbounded) count reduced to what configuration i should hold
  function automatic logic [31:0] fold(input longint unsigned ideal, input int i, input bit hi);
    longint unsigned mx, v;
    mx = (64'd1 << cfg_w(i)) - 64'd1;
    if (cfg_sat(i)) v = (ideal > mx) ? mx : ideal;
    else            v = ideal & mx;
    return hi ? v[63:32] : v[31:0];
  endfunction

  // Port index for a one-hot source on an even bit below 2*4, else -1
  function automatic int decode(input logic [7:0] s);
    if ($countones(s) != 1) return -1;
    for (int b = 0; b < 8; b++)
      if (s[b]) return (b % 2 == 0 && b / 2 < 4) ? b / 2 : -1;
    return -1;
  endfunction

  typedef struct {
    int               due;
    logic [2:0][31:0] data;
    bit               err;
  } exp_t;

  exp_t sbq[$];

  longint unsigned m_live[4][6];
  longint unsigned m_snap[4][6];
  longint unsigned m_unm_live, m_unm_snap;
  logic [63:0]     m_ts_snap;
  bit              pend_v;
  logic [7:0]      pend_src;
  logic [15:0]     pend_bytes;
  logic [4:0]      pend_flags;

  task automatic model_reset();
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 6; k++) begin
        m_live[p][k] = 0;
        m_snap[p][k] = 0;
      end
    m_unm_live = 0;
    m_unm_snap = 0;
    m_ts_snap  = '0;
    pend_v     = 0;
    sbq.delete();
  endtask

  function automatic logic [134:0] mk_attr(input logic [7:0] src, input logic [15:0] b,
                                           input logic [4:0] f);
    logic [134:0] a;
    for (int k = 0; k < 135; k++) a[k] = 1'($urandom_range(0, 1));
    a[134:127] = src;
    a[124:120] = f;
    a[119:104] = b;
    return a;
  endfunction

  task automatic set_pkt(input logic [7:0] src, input logic [15:0] b, input logic [4:0] f);
    pkt_attributes = mk_attr(src, b, f);
    pkt_valid      = 1'b1;
  endtask

  task automatic set_rd(input logic [7:0] p, input logic [2:0] s, input logic h);
    rd_req  = 1'b1;
    rd_port = p;
    rd_sel  = s;
    rd_hi   = h;
  endtask

  // Predict the effect of the coming edge, let it happen, then drop one-shot inputs
  task automatic tick();
    longint unsigned nl[4][6];
    longint unsigned nu;
    int   port;
    exp_t e;
    if (rd_req) begin
      e.due = cyc + 1;
      e.err = 0;
      for (int i = 0; i < 3; i++) begin
        if (rd_sel == 3'd6)      e.data[i] = rd_hi ? m_ts_snap[63:32] : m_ts_snap[31:0];
        else if (rd_sel == 3'd7) e.data[i] = fold(m_unm_snap, i, rd_hi);
        else if (rd_port >= 8'd4) begin
          e.data[i] = '0;
          e.err     = 1;
        end else e.data[i] = fold(m_snap[int'(rd_port)][int'(rd_sel)], i, rd_hi);
      end
      sbq.push_back(e);
    end
    nl = m_live;
    nu = m_unm_live;
    if (pend_v) begin
      port = decode(pend_src);
      if (port >= 0) begin
        nl[port][0] += 1;
        nl[port][1] += pend_bytes;
        nl[port][2] += (pend_flags[3] | pend_flags[4]);
        nl[port][3] += pend_flags[0];
        nl[port][4] += pend_flags[1];
        nl[port][5] += pend_flags[2];
      end else nu += 1;
    end
    for (int p = 0; p < 4; p++)
      if (rst_stats || clr_port_mask[p])
        for (int k = 0; k < 6; k++) nl[p][k] = 0;
    if (rst_stats) nu = 0;
    if (!stats_freeze) begin
      m_snap     = m_live;
      m_unm_snap = m_unm_live;
      m_ts_snap  = stamp_counter;
    end
    m_live     = nl;
    m_unm_live = nu;
    pend_v     = pkt_valid;
    pend_src   = pkt_attributes[134:127];
    pend_bytes = pkt_attributes[119:104];
    pend_flags = pkt_attributes[124:120];
    @(posedge clk);
    #1;
    pkt_valid     = 1'b0;
    rd_req        = 1'b0;
    rst_stats     = 1'b0;
    clr_port_mask = '0;
    stamp_counter = {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read_port(input logic [7:0] p);
    for (int s = 0; s < 6; s++)
      for (int h = 0; h < 2; h++) begin
        set_rd(p, 3'(s), 1'(h));
        tick();
      end
  endtask

  task automatic chk_zero_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_rd_data"}, 64'(rd_data[i]), 64'd0);
      chk({tag, "_rd_valid"}, 64'(rd_valid[i]), 64'd0);
      chk({tag, "_rd_err"}, 64'(rd_err[i]), 64'd0);
    end
  endtask

  // Monitor: every cycle, rd_valid must match the scoreboard head's due cycle
  logic [2:0][31:0] last_data;
  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (!reset) begin
      last_data = '0;
    end else begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        chk("stale_expectation", 64'(cyc), 64'(e.due));
      end
      ev = (sbq.size() > 0 && sbq[0].due == cyc);
      if (ev) e = sbq.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rd_valid_dut%0d", i), 64'(rd_valid[i]), 64'(ev));
        if (ev) begin
          chk($sformatf("rd_data_dut%0d", i), 64'(rd_data[i]), 64'(e.data[i]));
          chk($sformatf("rd_err_dut%0d", i), 64'(rd_err[i]), 64'(e.err));
        end else begin
          chk($sformatf("rd_hold_dut%0d", i), 64'(rd_data[i]), 64'(last_data[i]));
        end
      end
      last_data = rd_data;
    end
  end

  function automatic logic [7:0] rand_src();
    logic [7:0] pick;
    case ($urandom_range(0, 5))
      0: pick = 8'h01;
      1: pick = 8'h04;
      2: pick = 8'h10;
      3: pick = 8'h40;
      default: pick = 8'($urandom);
    endcase
    return pick;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    pkt_attributes = '0;
    pkt_valid      = 1'b0;
    stamp_counter  = 64'h0123_4567_89ab_cdef;
    stats_freeze   = 1'b0;
    rst_stats      = 1'b0;
    clr_port_mask  = '0;
    rd_req         = 1'b0;
    rd_port        = '0;
    rd_sel         = '0;
    rd_hi          = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset = 1'b1;

    // Post-reset sweep including invalid ports and both halves
    for (int p = 0; p < 6; p++)
      for (int s = 0; s < 8; s++)
        for (int h = 0; h < 2; h++) begin
          set_rd(8'(p), 3'(s), 1'(h));
          tick();
        end

    // Ten packets on port 2, 100 bytes, IP+TCP, three with VLAN_AD
    for (int n = 0; n < 10; n++) begin
      set_pkt(8'b0001_0000, 16'd100, (n < 3) ? 5'b10011 : 5'b00011);
      tick();
    end
    idle(3);
    for (int p = 0; p < 4; p++) read_port(8'(p));

    // Unmatched sources
    set_pkt(8'b0000_0011, 16'd7, 5'b00001); tick();
    set_pkt(8'b0000_0010, 16'd7, 5'b00001); tick();
    set_pkt(8'b0000_0000, 16'd7, 5'b00001); tick();
    idle(3);
    set_rd(8'd0, 3'd7, 1'b0); tick();
    read_port(8'd2);

    // Freeze, traffic on port 0, then unfreeze while reading pkt and timestamp
    stats_freeze = 1'b1;
    tick();
    for (int n = 0; n < 5; n++) begin
      set_pkt(8'b0000_0001, 16'(n + 60), 5'b00101);
      tick();
    end
    idle(2);
    set_rd(8'd0, 3'd0, 1'b0); tick();
    set_rd(8'd9, 3'd6, 1'b0); tick();
    set_rd(8'd9, 3'd6, 1'b1); tick();
    stats_freeze = 1'b0;
    for (int n = 0; n < 4; n++) begin
      set_rd(8'd0, 3'd0, 1'b0);
      tick();
    end

    // Port-1 clear coinciding with a port-1 counter update
    set_pkt(8'b0000_0100, 16'd40, 5'b00011); tick();
    clr_port_mask = 4'b0010;
    set_pkt(8'b0000_0001, 16'd40, 5'b00011);
    tick();
    idle(3);
    for (int p = 0; p < 4; p++) begin
      set_rd(8'(p), 3'd0, 1'b0);
      tick();
    end
    rst_stats = 1'b1;
    set_pkt(8'b0000_0000, 16'd1, 5'b0);
    tick();
    idle(3);
    set_rd(8'd0, 3'd7, 1'b0); tick();
    read_port(8'd2);

    // Random mixed traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) != 0) set_pkt(rand_src(), 16'($urandom), 5'($urandom));
      if ($urandom_range(0, 2) == 0)
        set_rd(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 15) == 0) clr_port_mask = 4'($urandom);
      if ($urandom_range(0, 80) == 0) rst_stats = 1'b1;
      if ($urandom_range(0, 25) == 0) stats_freeze = ~stats_freeze;
      tick();
    end
    stats_freeze = 1'b0;
    idle(3);
    for (int p = 0; p < 4; p++) read_port(8'(p));

    // Byte counter driven past 2^32-1 by back-to-back maximum-size packets
    rst_stats = 1'b1;
    tick();
    for (int n = 0; n < 65538; n++) begin
      set_pkt(8'b0100_0000, 16'hFFFF, 5'b00100);
      tick();
    end
    idle(3);
    read_port(8'd3);

    // Reset while a read and a packet are in flight
    set_rd(8'd3, 3'd1, 1'b0);
    set_pkt(8'b0100_0000, 16'd5, 5'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    model_reset();
    rd_req    = 1'b0;
    pkt_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero_outputs("held_reset");
    reset = 1'b1;
    idle(2);
    read_port(8'd3);
    set_rd(8'd0, 3'd7, 1'b1); tick();
    idle(3);

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
